button_reset_ctrl: RTL and testbench



---
 rtl/btn_ctrl_pkg.sv | 17 +
 rtl/sync_2ff.sv | 33 +++
 rtl/button_reset_ctrl.sv | 157 +++++++++++++++
 tb/tb_button_reset_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_ctrl_pkg.sv
// Shared types and sizing helpers for the push-button reset controller.
package btn_ctrl_pkg;

  // Press-handling states.
  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    RST_PULSE,
    HOLDOFF
  } btn_state_t;

  // Counter width able to hold every value from 0 up to long_cycles.
  function automatic int cnt_width(input int unsigned long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state values: shift the raw input through the two stages.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer stages, forced to RESET_VAL while reset is asserted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/button_reset_ctrl.sv
// Push-button classifier: glitch / short / long press, with a timed
// system-reset pulse (or a masked long-press strobe) and a holdoff window.
module button_reset_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned SHORT_CYCLES     = 1250000,
  parameter int unsigned LONG_CYCLES      = 125000000,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES   = 1250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  input  logic i_mask_rst,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_long_pending,
  output logic o_sys_rst,
  output logic o_busy
);

  // The counter is sized for LONG_CYCLES; the pulse and holdoff lengths are
  // loaded into the same counter and are expected not to exceed it.
  localparam int CNT_W = cnt_width(LONG_CYCLES);
  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic s_in;
  logic release_w;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_s_q, last_s_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             pend_q, pend_d;
  logic             sys_rst_q, sys_rst_d;
  logic             busy_q, busy_d;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_in),
    .o_q    (s_in)
  );

  assign release_w = ~s_in & last_s_q;

  // Next-state logic: press timing, classification at release, and the
  // down-counting pulse / holdoff timers on the shared counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_s_d = s_in;
    short_d  = 1'b0;
    long_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_in) begin
          state_d = PRESSED;
          cnt_d   = ONE_C;
        end
      end

      PRESSED: begin
        if (s_in) begin
          // Saturate so a button held forever never wraps into a short press.
          if (cnt_q != LONG_C) cnt_d = cnt_q + ONE_C;
        end else if (release_w) begin
          // cnt_q equals the number of cycles s_in was high.
          if (cnt_q >= LONG_C) begin
            if (i_mask_rst) begin
              long_d  = 1'b1;
              state_d = HOLDOFF;
              cnt_d   = HOLD_C;
            end else begin
              state_d = RST_PULSE;
              cnt_d   = PULSE_C;
            end
          end else if (cnt_q >= SHORT_C) begin
            short_d = 1'b1;
            state_d = HOLDOFF;
            cnt_d   = HOLD_C;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end

      RST_PULSE: begin
        // The last pulse cycle is the one where the counter reads 1.
        if (cnt_q <= ONE_C) begin
          state_d = HOLDOFF;
          cnt_d   = HOLD_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end

      HOLDOFF: begin
        // Presses are ignored here; a button still held at timeout must be
        // released before a new press can be accepted.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE_C;
        end else if (!s_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pend_d    = (state_d == PRESSED) && (cnt_d == LONG_C);
    sys_rst_d = (state_d == RST_PULSE);
    busy_d    = (state_d == RST_PULSE) || (state_d == HOLDOFF);
  end

  // State, counter and registered outputs; reset drops o_sys_rst at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_s_q  <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      pend_q    <= 1'b0;
      sys_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_s_q  <= last_s_d;
      short_q   <= short_d;
      long_q    <= long_d;
      pend_q    <= pend_d;
      sys_rst_q <= sys_rst_d;
      busy_q    <= busy_d;
    end
  end

  assign o_short_press  = short_q;
  assign o_long_press   = long_q;
  assign o_long_pending = pend_q;
  assign o_sys_rst      = sys_rst_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_button_reset_ctrl.sv
// Bench for button_reset_ctrl: directed and random press traces compared
// cycle by cycle against a press-interval reference model.
module tb_button_reset_ctrl;

  localparam int SHORT = 4;
  localparam int LONG  = 10;
  localparam int PULSE = 3;
  localparam int HOLD  = 5;
  localparam int MAXN  = 256;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_in = 1'b0;
  logic i_mask_rst = 1'b0;
  logic o_short_press, o_long_press, o_long_pending, o_sys_rst, o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Stimulus per cycle, synchronized view, observed and expected outputs.
  // Output vector order: {short, long, pending, sys_rst, busy}.
  bit         x_arr[MAXN];
  bit         m_arr[MAXN];
  bit         s_arr[MAXN];
  logic [4:0] obs_arr[MAXN];
  logic [4:0] exp_arr[MAXN];

  button_reset_ctrl #(
    .SHORT_CYCLES    (SHORT),
    .LONG_CYCLES     (LONG),
    .RST_PULSE_CYCLES(PULSE),
    .HOLDOFF_CYCLES  (HOLD)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_in          (i_in),
    .i_mask_rst    (i_mask_rst),
    .o_short_press (o_short_press),
    .o_long_press  (o_long_press),
    .o_long_pending(o_long_pending),
    .o_sys_rst     (o_sys_rst),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_in = 1'b0;
    i_mask_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      x_arr[i] = 1'b0;
      m_arr[i] = 1'b0;
    end
  endtask

  task automatic add_press(input int start, input int len);
    for (int k = 0; k < len; k++)
      if (start + k < MAXN) x_arr[start + k] = 1'b1;
  endtask

  // Reference model: walks the synchronized input as a list of high runs.
  // A run starting at t0 and ending at r has length r-t0; results appear at
  // r+1; holdoff lasts HOLD cycles past its start and then waits for s=0.
  task automatic model_trace(input int n, input bit pre);
    int t, t0, r, len, h0, e;
    for (int c = 0; c < n; c++) begin
      exp_arr[c] = 5'b0;
      s_arr[c] = (c == 0) ? 1'b0 : (c == 1) ? pre : x_arr[c - 2];
    end
    t = 0;
    while (t < n) begin
      t0 = t;
      while (t0 < n && !s_arr[t0]) t0++;
      if (t0 >= n) break;
      r = t0 + 1;
      while (r < n && s_arr[r]) r++;
      len = r - t0;
      for (int c = t0 + LONG; c <= r && c < n; c++) exp_arr[c][2] = 1'b1;
      if (r >= n) break;
      if (len < SHORT) begin
        t = r + 1;
        continue;
      end
      if (len >= LONG && !m_arr[r]) begin
        for (int c = r + 1; c <= r + PULSE && c < n; c++) exp_arr[c][1] = 1'b1;
        h0 = r + PULSE + 1;
      end else begin
        if (r + 1 < n) begin
          if (len >= LONG) exp_arr[r + 1][3] = 1'b1;
          else             exp_arr[r + 1][4] = 1'b1;
        end
        h0 = r + 1;
      end
      e = h0 + HOLD;
      while (e < n && s_arr[e]) e++;
      for (int c = r + 1; c <= e && c < n; c++) exp_arr[c][0] = 1'b1;
      t = e + 1;
    end
  endtask

  // Drive x/m for n cycles starting right after reset, then check each cycle.
  task automatic run_trace(input string name, input int n, input bit pre);
    for (int t = 0; t < n; t++) begin
      @(posedge i_clk);
      #1;
      i_in = x_arr[t];
      i_mask_rst = m_arr[t];
      @(negedge i_clk);
      obs_arr[t] = {o_short_press, o_long_press, o_long_pending, o_sys_rst, o_busy};
    end
    model_trace(n, pre);
    for (int t = 0; t < n; t++) begin
      tests_run++;
      if (obs_arr[t] !== exp_arr[t]) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: {short,long,pend,rst,busy} got %05b expected %05b",
                 name, t, obs_arr[t], exp_arr[t]);
      end
    end
    $display("[TB] trace %s: %0d cycles checked", name, n);
  endtask

  task automatic test_reset();
    logic [4:0] o;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_in = 1'b1;
    i_mask_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    o = {o_short_press, o_long_press, o_long_pending, o_sys_rst, o_busy};
    tests_run++;
    if (o !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: outputs got %05b expected 00000", o);
    end
    i_rst_n = 1'b1;
    i_in = 1'b0;
    i_mask_rst = 1'b0;
    @(negedge i_clk);
    o = {o_short_press, o_long_press, o_long_pending, o_sys_rst, o_busy};
    tests_run++;
    if (o !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_release: outputs got %05b expected 00000", o);
    end
    $display("[TB] reset: outputs %05b", o);
  endtask

  task automatic test_glitch();
    do_reset(); clear_stim();
    add_press(2, SHORT - 1);
    run_trace("glitch", 30, 1'b0);
  endtask

  task automatic test_short();
    do_reset(); clear_stim();
    add_press(2, SHORT);
    run_trace("short_exact", 30, 1'b0);
  endtask

  task automatic test_long_rst();
    do_reset(); clear_stim();
    add_press(2, LONG);
    run_trace("long_exact_rst", 40, 1'b0);
  endtask

  task automatic test_long_masked();
    do_reset(); clear_stim();
    add_press(2, 25);
    for (int t = 27; t < 60; t++) m_arr[t] = 1'b1;
    run_trace("long_masked", 60, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_stim();
    add_press(2, 6);
    add_press(10, 20);
    run_trace("back_to_back", 60, 1'b0);
  endtask

  task automatic test_random();
    int pos;
    for (int round = 0; round < 6; round++) begin
      do_reset(); clear_stim();
      pos = 2;
      while (pos < 120) begin
        add_press(pos, $urandom_range(1, 14));
        pos = pos + 15 + $urandom_range(1, 12) - 14 + $urandom_range(0, 13);
      end
      for (int t = 0; t < 160; t++) m_arr[t] = bit'($urandom_range(0, 1));
      run_trace($sformatf("random%0d", round), 160, 1'b0);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int seen;
    int shorts;
    do_reset(); clear_stim();
    seen = 0;
    for (int k = 0; k < 80 && seen < 2; k++) begin
      @(posedge i_clk);
      #1;
      i_in = (k < LONG);
      @(negedge i_clk);
      if (o_sys_rst) seen++;
    end
    tests_run++;
    if (seen < 2) begin
      tests_failed++;
      $display("FAIL mid_pulse_wait: sys_rst cycles seen %0d required 2 (timeout)", seen);
    end
    i_in = 1'b1;
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_sys_rst, o_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_pulse_async: {rst,busy} got %02b expected 00", {o_sys_rst, o_busy});
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int t = 0; t < 3; t++) x_arr[t] = 1'b1;
    run_trace("after_reset", 30, 1'b1);
    shorts = 0;
    for (int t = 0; t < 30; t++) if (obs_arr[t][4]) shorts++;
    tests_run++;
    if (shorts != 1) begin
      tests_failed++;
      $display("FAIL after_reset_short_count: got %0d strobes expected 1", shorts);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short();
    test_long_rst();
    test_long_masked();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
